regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have a single clock and reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock, shared with the 32x32 register file.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_ready  output  1  requester A write accepted this cycle.
REQ-006 a_addr / a_data / a_ben  input  5 / 32 / 4  requester A destination, data, byte enables.
REQ-007 b_valid  input  1  requester B (load writeback) has a write pending.
REQ-008 b_ready  output  1  requester B write accepted this cycle.
REQ-009 b_addr / b_data / b_ben  input  5 / 32 / 4  requester B destination, data, byte enables.
REQ-010 clr_req  input  1  single-cycle pulse: zero registers 1..31.
REQ-011 clr_busy  output  1  clear sequence in progress.
REQ-012 rd_addr / rd_in / rd_ben  output  5 / 32 / 4  registered drive of the register file write port (Rd_addr, Rd_in, Rd_Byte_w_en).
REQ-013 last_grant  output  1  0 = A granted last, 1 = B granted last.

Function
REQ-014 The block SHALL have FSM states IDLE and CLEAR.
REQ-015 Transfer rule: X is accepted when x_valid and x_ready are both high at a rising edge.
REQ-016 x_ready: high only in IDLE with clr_req low, and only for the granted requester.
REQ-017 x_ready: may depend combinationally on a_valid/b_valid; at most one ready high per cycle.
REQ-018 Arbitration, one valid: grant that requester.
REQ-019 Arbitration, both valid: grant the requester not equal to last_grant (round-robin).
REQ-020 last_grant SHALL update only on an accepted transfer.
REQ-021 Latency: a transfer accepted at edge N SHALL appear on rd_addr/rd_in/rd_ben from edge N to edge N+1, so the register file writes it at edge N+1.
REQ-022 Writes SHALL be back-to-back capable: one accepted transfer per cycle, no bubbles.
REQ-023 In any cycle with no accepted transfer and not in CLEAR, rd_ben SHALL be 4'b0000, rd_addr 0, rd_in 0.
REQ-024 Address 0: a transfer to address 0 SHALL be accepted normally, with rd_ben forced to 4'b0000.
REQ-025 Byte enables SHALL pass unmodified for addresses 1..31, including 4'b0000.
REQ-026 IDLE->CLEAR: on clr_req high at an edge in IDLE; requests present that cycle are not accepted (clear wins).
REQ-027 CLEAR drive: for 31 consecutive cycles, rd_addr = 1,2,...,31, rd_in = 0, rd_ben = 4'b1111.
REQ-028 CLEAR->IDLE: after the cycle driving address 31, the block returns to IDLE; arbitration resumes on the next edge.
REQ-029 clr_busy SHALL be high exactly during the 31 CLEAR drive cycles.
REQ-030 clr_req while in CLEAR SHALL be ignored (no restart, no extension).
REQ-031 Both readys SHALL be low throughout CLEAR; valid requesters hold their request.

Reset
REQ-032 On rst assertion, immediately and regardless of clk: state IDLE, rd_addr=0, rd_in=0, rd_ben=0, clr_busy=0, last_grant=1 (A wins the first tie).
REQ-033 Reset mid-CLEAR SHALL abort the sequence; the clear is not resumed after reset.
REQ-034 Readys SHALL be low while rst is high.

Verification
REQ-035 Reset, then a_valid only, addr 5, data 0xDEADBEEF, ben F -> a_ready=1; next cycle rd_addr=5, rd_in=0xDEADBEEF, rd_ben=F; register 5 reads 0xDEADBEEF afterwards.
REQ-036 Both valid for 4 cycles after reset (A addr 3, B addr 4) -> grants A,B,A,B; last_grant toggles 0,1,0,1; no idle cycles on rd_ben.
REQ-037 clr_req pulse with a_valid high -> a_ready=0; clr_busy high 31 cycles; rd_addr steps 1..31 with rd_ben=F and rd_in=0; A is accepted on the first edge after clr_busy falls; all registers 1..31 read 0 before A's write.
REQ-038 A writes addr 0, data 0x12345678, ben F -> rd_ben=0; register 0 still reads 0.
REQ-039 B writes addr 7, data 0xAABBCCDD, ben 4'b0101 onto initial value 7 -> register 7 reads 0x00BB00DD.
REQ-040 rst asserted at CLEAR cycle 10 -> outputs zero asynchronously; after release the block is in IDLE; registers 11..31 keep their prior values.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter driving the 32x32 register file write port,
// with a 31-cycle sequence that zeroes registers 1..31.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic [3:0]  a_ben,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic [3:0]  b_ben,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_in,
    output logic [3:0]  rd_ben,
    output logic        last_grant
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam logic [AW-1:0] FIRST_CLR_ADDR = AW'(1);
    localparam logic [AW-1:0] LAST_CLR_ADDR  = AW'(31);
    localparam logic [BW-1:0] BEN_ALL        = {BW{1'b1}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_rd_addr;
    logic [AW-1:0]   w_rd_addr_nxt;
    logic [DW-1:0]   r_rd_in;
    logic [DW-1:0]   w_rd_in_nxt;
    logic [BW-1:0]   r_rd_ben;
    logic [BW-1:0]   w_rd_ben_nxt;
    logic            r_clr_busy;
    logic            w_clr_busy_nxt;
    logic            r_last_grant;
    logic            w_last_grant_nxt;
    logic            w_arb_en;
    logic            w_grant_a;
    logic            w_grant_b;

    // Lone requester wins; on a tie the requester not granted last wins.
    always_comb begin
        w_arb_en  = (r_state == S_IDLE) && !clr_req && !rst;
        w_grant_a = a_valid && (!b_valid || r_last_grant);
        w_grant_b = b_valid && (!a_valid || !r_last_grant);
    end

    assign a_ready = w_arb_en && w_grant_a;
    assign b_ready = w_arb_en && w_grant_b;

    // Next-state and write-port drive; an idle cycle drives all zeros.
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_addr_nxt    = '0;
        w_rd_in_nxt      = '0;
        w_rd_ben_nxt     = '0;
        w_clr_busy_nxt   = 1'b0;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt    = S_CLEAR;
                    w_rd_addr_nxt  = FIRST_CLR_ADDR;
                    w_rd_ben_nxt   = BEN_ALL;
                    w_clr_busy_nxt = 1'b1;
                end else if (a_ready) begin
                    w_rd_addr_nxt    = a_addr;
                    w_rd_in_nxt      = a_data;
                    w_rd_ben_nxt     = (a_addr == '0) ? '0 : a_ben;
                    w_last_grant_nxt = 1'b0;
                end else if (b_ready) begin
                    w_rd_addr_nxt    = b_addr;
                    w_rd_in_nxt      = b_data;
                    w_rd_ben_nxt     = (b_addr == '0) ? '0 : b_ben;
                    w_last_grant_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                // clr_req is deliberately ignored here: the sweep never restarts.
                if (r_rd_addr == LAST_CLR_ADDR) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rd_addr_nxt  = r_rd_addr + AW'(1);
                    w_rd_ben_nxt   = BEN_ALL;
                    w_clr_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears any clear sweep in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_rd_in      <= '0;
            r_rd_ben     <= '0;
            r_clr_busy   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_rd_in      <= w_rd_in_nxt;
            r_rd_ben     <= w_rd_ben_nxt;
            r_clr_busy   <= w_clr_busy_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    assign rd_addr    = r_rd_addr;
    assign rd_in      = r_rd_in;
    assign rd_ben     = r_rd_ben;
    assign clr_busy   = r_clr_busy;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// against a queue-based reference model and a shadow register file.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, rd_addr;
    logic [31:0] a_data, b_data, rd_in;
    logic [3:0]  a_ben, b_ben, rd_ben;
    logic        clr_req, clr_busy, last_grant;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data), .a_ben(a_ben),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_ben(b_ben),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .rd_addr(rd_addr), .rd_in(rd_in), .rd_ben(rd_ben), .last_grant(last_grant)
    );

    // Register file written by the DUT port; preloaded with reg[i] = i.
    logic [31:0] rf [32];
    logic        rf_load;
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (rd_ben[b]) rf[rd_addr][8*b +: 8] <= rd_in[8*b +: 8];
        end
    end

    // Reference model: expected write-port drive, pending clear drives, registers.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } drv_t;
    drv_t        q[$];
    logic [31:0] m_reg [32];
    logic        m_last, m_busy;
    drv_t        e;

    int n_pass = 0, n_total = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("rd_addr", 32'(rd_addr), 32'(e.a));
        chk("rd_in", rd_in, e.d);
        chk("rd_ben", 32'(rd_ben), 32'(e.be));
        chk("clr_busy", 32'(clr_busy), 32'(m_busy));
        chk("last_grant", 32'(last_grant), 32'(m_last));
    endtask

    task automatic cmp_rf();
        for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), rf[i], m_reg[i]);
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_last = 1'b1;
        e = '{5'd0, 32'd0, 4'd0};
    endtask

    // One clock cycle: drive, check readys, clock, update model, check drive.
    task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad, input logic [3:0] abe,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic [3:0] bbe,
                       input logic clr);
        logic ea, eb;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad; a_ben = abe;
        b_valid = bv; b_addr = ba; b_data = bd; b_ben = bbe;
        clr_req = clr;
        #1;
        ea = 1'b0; eb = 1'b0;
        if (!m_busy && !clr) begin
            if (av && bv) begin
                ea = m_last;
                eb = !m_last;
            end else begin
                ea = av;
                eb = bv;
            end
        end
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        @(posedge clk);
        for (int b = 0; b < 4; b++)
            if (e.be[b]) m_reg[e.a][8*b +: 8] = e.d[8*b +: 8];
        e = '{5'd0, 32'd0, 4'd0};
        if (m_busy) begin
            if (q.size() > 0) e = q.pop_front();
            else m_busy = 1'b0;
        end else if (clr) begin
            for (int k = 1; k <= 31; k++) q.push_back('{5'(k), 32'd0, 4'hF});
            e = q.pop_front();
            m_busy = 1'b1;
        end else if (ea) begin
            e = '{aa, ad, (aa == 5'd0) ? 4'd0 : abe};
            m_last = 1'b0;
        end else if (eb) begin
            e = '{ba, bd, (ba == 5'd0) ? 4'd0 : bbe};
            m_last = 1'b1;
        end
        #1;
        chk_outs();
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; clr_req = 1'b0;
        rst = 1'b0; rf_load = 1'b0;
        @(posedge clk);
        #1;
        chk_outs();
    endtask

    // Reset asserted mid-cycle with A requesting: outputs clear without a clock edge.
    task automatic reset_mid();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1; a_ben = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outs();
        chk("a_ready_rst", 32'(a_ready), 32'd0);
        release_rst();
    endtask

    initial begin
        rst = 1'b1; rf_load = 1'b1;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0; a_ben = 4'hF;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h0; b_ben = 4'hF;
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
        model_reset();
        #1;
        chk_outs();
        chk("a_ready_rst", 32'(a_ready), 32'd0);
        chk("b_ready_rst", 32'(b_ready), 32'd0);
        @(posedge clk);
        release_rst();

        // Single A write, B partial-byte write, address-0 write.
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0);
        cyc(1'b1, 5'd0, 32'h12345678, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
        idle();
        chk("rf5_value", rf[5], 32'hDEADBEEF);
        chk("rf7_value", rf[7], 32'h00BB00DD);
        chk("rf0_value", rf[0], 32'h0);
        cmp_rf();

        // Round-robin tie after reset: A,B,A,B back to back.
        reset_mid();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'd3, 32'h3000 + 32'(i), 4'hF, 1'b1, 5'd4, 32'h4000 + 32'(i), 4'hF, 1'b0);
        idle();
        cmp_rf();

        // Clear with A held; a second clr_req mid-sweep must be ignored.
        cyc(1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1);
        for (int i = 0; i < 31; i++)
            cyc(1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0, i == 5);
        cmp_rf();
        cyc(1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
        idle();
        chk("rf9_after_clear", rf[9], 32'hCAFEF00D);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom), 5'($urandom), $urandom, 4'($urandom),
                1'($urandom), 5'($urandom), $urandom, 4'($urandom),
                ($urandom_range(0, 49) == 0));
        for (int i = 0; i < 33; i++) idle();
        cmp_rf();

        // Reset during clear cycle 10: sweep aborted, upper registers untouched.
        cyc(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1);
        for (int i = 0; i < 9; i++) idle();
        reset_mid();
        cyc(1'b1, 5'd12, 32'h0BADBEEF, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
        idle();
        cmp_rf();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
